// File: rtl/ser_pkg.sv
// Shared types and constants for the serial frame demultiplexer.
// State encodings follow the order the fields arrive on the wire.
package ser_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_LEN_W = 4;

    // Field order on the wire: start bit, address, length, payload
    localparam int FLD_START = 0;
    localparam int FLD_ADDR  = 1;
    localparam int FLD_LEN   = 2;
    localparam int FLD_DATA  = 3;

    localparam logic START_BIT = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'(FLD_START),
        ADDR = 2'(FLD_ADDR),
        LEN  = 2'(FLD_LEN),
        DATA = 2'(FLD_DATA)
    } ser_state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable, clearable down-counter shared by the address, length and payload phases.
// It holds at zero instead of wrapping, so a full-scale length never rolls over.
module ser_bit_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (count != '0))
            count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ser_frame_demux.sv
// Serial frame receiver: start bit, MSB-first address and length, then payload
// steered onto one of NCH registered serial outputs.
module ser_frame_demux
    import ser_pkg::*;
#(
    parameter  int NCH   = DEF_NCH,
    parameter  int LEN_W = DEF_LEN_W,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            serin,
    output logic [NCH-1:0]  sout,
    output logic [NCH-1:0]  sout_valid,
    output logic [CH_W-1:0] cur_ch,
    output logic            busy,
    output logic            done,
    output logic            addr_err
);

    localparam logic [CH_W:0]    NCH_V     = (CH_W + 1)'(NCH);
    localparam logic [LEN_W-1:0] ADDR_LAST = LEN_W'(CH_W - 1);
    localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(LEN_W - 1);

    ser_state_t       state, state_nxt;
    logic [CH_W-1:0]  addr_sr, addr_new;
    logic [LEN_W-1:0] len_sr, len_new;
    logic             start, in_range;
    logic [NCH-1:0]   vld_hit;

    logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
    logic [LEN_W-1:0] cnt_val;

    logic [NCH-1:0]   sout_d, vld_d;
    logic [CH_W-1:0]  ch_d;
    logic             done_d, err_d;

    assign start    = (serin == START_BIT);
    // Value the shift register will hold once the current bit is in
    assign addr_new = CH_W'({addr_sr, serin});
    assign len_new  = LEN_W'({len_sr, serin});
    assign in_range = ({1'b0, cur_ch} < NCH_V);
    assign vld_hit  = in_range ? (NCH'(1) << cur_ch) : '0;
    assign busy     = (state != IDLE);

    ser_bit_counter #(.W(LEN_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b1;
        cnt_val   = ADDR_LAST;
        case (state)
            IDLE: begin
                cnt_clr = !start;
                if (start) begin
                    state_nxt = ADDR;
                    cnt_load  = 1'b1;
                end
            end
            ADDR: if (cnt_tc) begin
                state_nxt = LEN;
                cnt_load  = 1'b1;
                cnt_val   = LEN_LAST;
            end
            LEN: if (cnt_tc) begin
                if (len_new == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DATA;
                    cnt_load  = 1'b1;
                    cnt_val   = len_new - 1'b1;
                end
            end
            DATA: if (cnt_tc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; an empty frame ends straight from LEN
    always_comb begin
        sout_d = '0;
        vld_d  = '0;
        ch_d   = cur_ch;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state)
            ADDR: if (cnt_tc) ch_d = addr_new;
            LEN: if (cnt_tc && (len_new == '0)) begin
                done_d = 1'b1;
                err_d  = !in_range;
            end
            DATA: begin
                vld_d  = vld_hit;
                sout_d = serin ? vld_hit : '0;
                if (cnt_tc) begin
                    done_d = 1'b1;
                    err_d  = !in_range;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_sr    <= '0;
            len_sr     <= '0;
            sout       <= '0;
            sout_valid <= '0;
            cur_ch     <= '0;
            done       <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            sout       <= sout_d;
            sout_valid <= vld_d;
            cur_ch     <= ch_d;
            done       <= done_d;
            addr_err   <= err_d;
            if (state == IDLE) begin
                addr_sr <= '0;
                len_sr  <= '0;
            end else if (state == ADDR) begin
                addr_sr <= addr_new;
            end else if (state == LEN) begin
                len_sr  <= len_new;
            end
        end
    end

endmodule
